// File: rtl/lshift_deser.sv
// Serial-in / parallel-out deserializer for the lshift_reg serial path.
// Optional even-parity trailer bit enabled by defining LSHIFT_DESER_PARITY_EN.
module lshift_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    output logic             busy,
`ifdef LSHIFT_DESER_PARITY_EN
    output logic             overrun,
    output logic             parity_err
`else
    output logic             overrun
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Handshake: a serial bit transfers on any posedge where ser_valid=1 while a
    // frame is open; out_valid and overrun are single-cycle registered pulses.
    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shifted;
    logic             last_data;

    assign shifted   = MSB_FIRST ? {shadow[WIDTH-2:0], ser_in}
                                 : {ser_in, shadow[WIDTH-1:1]};
    assign last_data = ser_valid && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= ST_IDLE;
            count      <= '0;
            shadow     <= '0;
            par_out    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef LSHIFT_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SHIFT;
                        busy   <= 1'b1;
                        count  <= '0;
                        shadow <= '0;
                    end
                end
                ST_SHIFT: begin
`ifdef LSHIFT_DESER_PARITY_EN
                    // Data bits never complete a frame here, so any start aborts it.
                    if (start) begin
                        overrun <= 1'b1;
                        count   <= '0;
                        shadow  <= '0;
                    end else if (ser_valid) begin
                        shadow <= shifted;
                        count  <= count + CW'(1);
                        if (last_data) state <= ST_PARITY;
                    end
`else
                    if (start && !last_data) begin
                        overrun <= 1'b1;
                        count   <= '0;
                        shadow  <= '0;
                    end else if (last_data) begin
                        par_out   <= shifted;
                        out_valid <= 1'b1;
                        count     <= '0;
                        shadow    <= '0;
                        state     <= start ? ST_SHIFT : ST_IDLE;
                        busy      <= start;
                    end else if (ser_valid) begin
                        shadow <= shifted;
                        count  <= count + CW'(1);
                    end
`endif
                end
`ifdef LSHIFT_DESER_PARITY_EN
                ST_PARITY: begin
                    if (ser_valid) begin
                        par_out    <= shadow;
                        parity_err <= (^shadow) ^ ser_in;
                        out_valid  <= 1'b1;
                        count      <= '0;
                        shadow     <= '0;
                        state      <= start ? ST_SHIFT : ST_IDLE;
                        busy       <= start;
                    end else if (start) begin
                        overrun <= 1'b1;
                        count   <= '0;
                        shadow  <= '0;
                        state   <= ST_SHIFT;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lshift_deser.sv
// Self-checking bench for lshift_deser (WIDTH=8, MSB_FIRST=1), scoreboard on out_valid.
module tb_lshift_deser;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       ser_in;
    logic       ser_valid;
    logic [7:0] par_out;
    logic       out_valid;
    logic       busy;
    logic       overrun;
`ifdef LSHIFT_DESER_PARITY_EN
    logic       parity_err;
    logic       perr_q[$];
`endif

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ov_count = 0;
    int         ovr_count = 0;
    int         pushed = 0;
    int         base;

    lshift_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .par_out    (par_out),
        .out_valid  (out_valid),
        .busy       (busy),
`ifdef LSHIFT_DESER_PARITY_EN
        .overrun    (overrun),
        .parity_err (parity_err)
`else
        .overrun    (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every out_valid pulse pops one expected word.
    always @(negedge clk) begin
        if (overrun) ovr_count++;
        if (out_valid) begin
            ov_count++;
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else check("par_out", par_out, exp_q.pop_front());
`ifdef LSHIFT_DESER_PARITY_EN
            if (perr_q.size() != 0) check("parity_err", parity_err, perr_q.pop_front());
`endif
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic with_start, input logic completes);
        ser_in = b; ser_valid = 1'b1; start = with_start;
        @(posedge clk); #1;
        ser_valid = 1'b0; start = 1'b0; ser_in = 1'($urandom_range(0, 1));
        check(completes ? "out_valid_latency" : "out_valid_early", out_valid, completes);
    endtask

    // Start strobe with ser_valid high: that bit must not be sampled.
    task automatic do_start();
        start = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ser_valid = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_word(input logic [7:0] w, input int gmin, input int gmax,
                             input logic start_last, input logic bad_par);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(gmin, gmax));
`ifdef LSHIFT_DESER_PARITY_EN
            send_bit(w[7-i], 1'b0, 1'b0);
`else
            if (i == 7) begin
                exp_q.push_back(w); pushed++;
            end
            send_bit(w[7-i], (i == 7) && start_last, i == 7);
`endif
        end
`ifdef LSHIFT_DESER_PARITY_EN
        idle($urandom_range(gmin, gmax));
        exp_q.push_back(w); perr_q.push_back(bad_par); pushed++;
        send_bit((^w) ^ bad_par, start_last, 1'b1);
`endif
        idle(1);
        check("out_valid_width", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
        idle(2);
        check("rst_par_out", par_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
`ifdef LSHIFT_DESER_PARITY_EN
        check("rst_parity_err", parity_err, 0);
`endif
        rstn = 1'b0;
        idle(1);

        // Back-to-back bits, ser_valid ignored in IDLE
        ser_valid = 1'b1; ser_in = 1'b1; idle(2); ser_valid = 1'b0;
        check("idle_busy", busy, 0);
        do_start();
        send_word(8'h01, 0, 0, 1'b0, 1'b0);
        check("busy_after_01", busy, 0);

        // Gaps between bits are not counted
        do_start();
        send_word(8'hA5, 1, 3, 1'b0, 1'b0);
        check("busy_after_a5", busy, 0);

        // Restart mid-frame gives one overrun pulse
        base = ovr_count;
        do_start();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        do_start();
        check("overrun_pulse", overrun, 1);
        idle(1);
        check("overrun_width", overrun, 0);
        send_word(8'h3C, 0, 1, 1'b0, 1'b0);
        check("overrun_count_3c", ovr_count - base, 1);

        // Start coincident with the completing bit chains into the next frame
        base = ovr_count;
        do_start();
        send_word(8'h80, 0, 0, 1'b1, 1'b0);
        check("busy_chained", busy, 1);
        send_word(8'hFF, 0, 0, 1'b0, 1'b0);
        check("overrun_count_chain", ovr_count - base, 0);
        check("busy_after_ff", busy, 0);

        // Reset during bit 5 discards the frame
        base = ov_count;
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        ser_valid = 1'b1; ser_in = 1'b1; rstn = 1'b1;
        @(posedge clk); #1;
        ser_valid = 1'b0; rstn = 1'b0;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_par_out", par_out, 0);
        check("rst_mid_busy", busy, 0);
        idle(2);
        check("rst_mid_no_word", ov_count - base, 0);

`ifdef LSHIFT_DESER_PARITY_EN
        do_start();
        send_word(8'h01, 0, 0, 1'b0, 1'b0);
        do_start();
        send_word(8'h01, 0, 0, 1'b0, 1'b1);
        check("parity_err_held", parity_err, 1);
`endif

        idle(2);
        check("words_seen", ov_count, pushed);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lshift_deser.md
Name: lshift_deser

Overview:
- Receive end of the lshift_reg serial path: captures a bit stream taken from the sender's op[7] and reassembles it into a parallel word.
- Serial-in / parallel-out deserializer with explicit frame start, per-bit qualifier, bit counter and a small FSM.
- Sits between a shift-register transmitter and downstream parallel logic; presents each completed word with a one-cycle valid pulse.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- MSB_FIRST, 1, 1 = first received bit lands in par_out[WIDTH-1] (matches a left shifter); 0 = first bit lands in par_out[0].

Ports:
- clk  input  1  single clock; all logic on posedge.
- rstn  input  1  synchronous reset, active-high (1 = reset), sampled on posedge clk.
- start  input  1  frame start strobe.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in qualifier; a bit is sampled only when 1.
- par_out  output  WIDTH  last completed word.
- out_valid  output  1  one-cycle pulse: par_out updated this cycle.
- busy  output  1  1 while a frame is in progress.
- overrun  output  1  one-cycle pulse: frame aborted by a new start.
- parity_err  output  1  present only with the optional feature.

Behaviour:
- Reset (rstn=1 at posedge): state=IDLE, bit count=0, shadow=0, par_out=0, out_valid=0, busy=0, overrun=0, parity_err=0. Reset mid-frame discards the partial word; no out_valid.
- States: IDLE, SHIFT (plus PARITY with the optional feature). busy = (state != IDLE), registered.
- IDLE: ser_valid ignored. start=1 -> SHIFT, count=0, shadow=0. The start cycle never samples ser_in, even if ser_valid=1.
- SHIFT, ser_valid=1:
  - MSB_FIRST=1: shadow <= {shadow[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: shadow <= {ser_in, shadow[WIDTH-1:1]}.
  - count increments.
- SHIFT, ser_valid=0: hold; gaps of any length allowed.
- Completion: the Nth sampled bit (N=WIDTH) updates par_out with the assembled word including that bit, on the same edge. out_valid=1 for the following cycle only. FSM -> IDLE.
  - Latency: out_valid high exactly one cycle after the last bit's sampling edge.
- par_out holds its value until the next completion or reset.
- start in SHIFT before the last bit: partial word discarded; overrun=1 for one cycle; count=0; stays in SHIFT. ser_in in that cycle is not sampled.
- start coincident with the last bit: word completes normally (out_valid next cycle, no overrun); FSM goes to SHIFT with count=0 instead of IDLE.
- Count width: $clog2(WIDTH+1); no wrap occurs because the frame ends at WIDTH.

Optional Feature:
- Macro: LSHIFT_DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits, FSM enters PARITY.
  - The next qualified bit is an even-parity bit.
  - par_out and out_valid update on that bit's edge instead of the last data bit.
  - parity_err = (^word) ^ parity_bit, valid in the out_valid cycle and held until the next completion.
  - start in PARITY = overrun (same rules as SHIFT).
- Undefined: no PARITY state, no parity_err port; behaviour exactly as above.

Test Plan (WIDTH=8, MSB_FIRST=1):
- Hold rstn=1 for 2 clocks -> par_out=0, out_valid=0, busy=0, overrun=0.
- start, then 8 consecutive valid bits 0,0,0,0,0,0,0,1 -> out_valid high exactly the cycle after the 8th bit; par_out=8'h01; busy=0 afterwards.
- start, bits of 8'hA5 MSB-first with ser_valid low 1–3 cycles between bits -> par_out=8'hA5; single out_valid pulse; gaps not counted.
- start, 3 bits, then start again, then 8 bits of 8'h3C -> one overrun pulse at the second start; single out_valid; par_out=8'h3C.
- Frame 8'h80 with start asserted on its 8th bit, then 8 bits of 8'hFF -> out_valid with 8'h80, no overrun, then out_valid with 8'hFF.
- Assert rstn during bit 5 of a frame -> no out_valid; par_out=0; busy=0. Parity build: 8'h01 plus parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
